// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: address/control sequencer for one convolution layer (CLEAR, D-tap MAC, WRITE per row, per kernel).
// Optional busy-cycle counter port cycleCount when SEQ_PERF_COUNTER_EN is defined.
module conv_layer_sequencer #(
    parameter int depth   = 3,
    parameter int ABuffer = 11
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [ABuffer-1:0]   cfgRows,
    input  logic [depth:0]       cfgKernels,
    input  logic                 cfgPool,
    output logic                 busy,
    output logic                 done,
    output logic [ABuffer-1:0]   nReadAddress,
    output logic [ABuffer-1:0]   nWriteAddress,
    output logic [ABuffer-1:0]   kBuffAddress,
    output logic [2*depth-1:0]   kernelDistControl,
    output logic [1:0]           convUnitControl,
    output logic [1:0]           poolUnitControl,
    output logic                 bufSel
`ifdef SEQ_PERF_COUNTER_EN
    ,
    output logic [31:0]          cycleCount
`endif
);
    localparam int D = 1 << depth;

    typedef enum logic [2:0] {IDLE, CLEAR, MAC, WRITE, SWAP, DONE} stateT;

    stateT              state, nextState;
    logic [ABuffer-1:0] rows, rCnt, wrBase;
    logic [depth:0]     kernels, kCnt;
    logic [depth-1:0]   tCnt;
    logic               pool, lastRow, lastKernel, lastTap;

    assign lastRow    = rCnt == rows - 1'b1;
    assign lastKernel = kCnt == kernels - 1'b1;
    assign lastTap    = tCnt == depth'(D - 1);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = (cfgRows == '0 || cfgKernels == '0) ? DONE : CLEAR;
            CLEAR:   nextState = MAC;
            MAC:     nextState = lastTap ? WRITE : MAC;
            WRITE:   nextState = !lastRow ? MAC : (!lastKernel ? CLEAR : SWAP);
            SWAP:    nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            rows    <= '0;
            kernels <= '0;
            pool    <= 1'b0;
            kCnt    <= '0;
            rCnt    <= '0;
            tCnt    <= '0;
            bufSel  <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: if (start) begin
                    rows    <= cfgRows;
                    kernels <= cfgKernels;
                    pool    <= cfgPool;
                    kCnt    <= '0;
                    rCnt    <= '0;
                    tCnt    <= '0;
                end
                MAC:  tCnt <= tCnt + 1'b1;
                WRITE: if (!lastRow) rCnt <= rCnt + 1'b1;
                    else if (!lastKernel) begin
                        kCnt <= kCnt + 1'b1;
                        rCnt <= '0;
                    end
                SWAP: bufSel <= ~bufSel;
                default: ;
            endcase
        end
    end

`ifdef SEQ_PERF_COUNTER_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cycleCount <= '0;
        else cycleCount <= (state == IDLE && start) ? '0 : (busy ? cycleCount + 1'b1 : cycleCount);
    end
`endif

    // Pooled layers write two rows into one output slot.
    assign wrBase            = ABuffer'(kCnt) * rows + rCnt;
    assign busy              = state != IDLE;
    assign done              = state == DONE;
    assign convUnitControl   = state == CLEAR ? 2'b01 : state == MAC ? 2'b10 : state == WRITE ? 2'b11 : 2'b00;
    assign poolUnitControl   = (state == WRITE && pool) ? ((rCnt[0] || lastRow) ? 2'b10 : 2'b01) : 2'b00;
    assign nReadAddress      = state == MAC ? rCnt : '0;
    assign nWriteAddress     = state == WRITE ? (pool ? wrBase >> 1 : wrBase) : '0;
    assign kBuffAddress      = state == MAC ? ABuffer'(kCnt) * ABuffer'(D) + ABuffer'(tCnt) : '0;
    assign kernelDistControl = state == MAC ? {tCnt, kCnt[depth-1:0]} : '0;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: table-driven and randomized layer runs checked cycle-by-cycle against a schedule model.
module tb_conv_layer_sequencer;
    localparam int depth = 3, ABuffer = 11, D = 8;

    logic CLK = 0, RST_N = 0, start = 0, cfgPool = 0;
    logic [ABuffer-1:0] cfgRows = '0;
    logic [depth:0] cfgKernels = '0;
    logic busy, done, bufSel;
    logic [ABuffer-1:0] nReadAddress, nWriteAddress, kBuffAddress;
    logic [2*depth-1:0] kernelDistControl;
    logic [1:0] convUnitControl, poolUnitControl;
`ifdef SEQ_PERF_COUNTER_EN
    logic [31:0] cycleCount;
`endif

    conv_layer_sequencer #(.depth(depth), .ABuffer(ABuffer)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .cfgRows(cfgRows), .cfgKernels(cfgKernels),
        .cfgPool(cfgPool), .busy(busy), .done(done), .nReadAddress(nReadAddress),
        .nWriteAddress(nWriteAddress), .kBuffAddress(kBuffAddress),
        .kernelDistControl(kernelDistControl), .convUnitControl(convUnitControl),
        .poolUnitControl(poolUnitControl), .bufSel(bufSel)
`ifdef SEQ_PERF_COUNTER_EN
        , .cycleCount(cycleCount)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int rows;
        int kernels;
        bit pool;
        int expBusy;
    } vecT;

    int checks = 0, errors = 0;
    logic expBuf = 0;
    logic [45:0] expQ[$];

    function automatic logic [45:0] rec(bit b, bit dn, logic [1:0] cv, logic [1:0] pl, int nr, int nw, int ka, int kd, bit bs);
        logic [10:0] a1, a2, a3;
        logic [5:0] a4;
        a1 = nr[10:0];
        a2 = nw[10:0];
        a3 = ka[10:0];
        a4 = kd[5:0];
        return {b, dn, cv, pl, a1, a2, a3, a4, bs};
    endfunction

    function automatic logic [45:0] actual();
        return {busy, done, convUnitControl, poolUnitControl, nReadAddress, nWriteAddress,
                kBuffAddress, kernelDistControl, bufSel};
    endfunction

    task automatic chkRec(string nm, logic [45:0] act, logic [45:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chkInt(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Expected per-cycle schedule derived directly from the layer loop nest.
    task automatic buildTrace(int R, int K, bit p);
        int wr;
        expQ.delete();
        if (R == 0 || K == 0) begin
            expQ.push_back(rec(1, 1, 0, 0, 0, 0, 0, 0, expBuf));
            return;
        end
        for (int k = 0; k < K; k++) begin
            expQ.push_back(rec(1, 0, 2'b01, 0, 0, 0, 0, 0, expBuf));
            for (int r = 0; r < R; r++) begin
                for (int t = 0; t < D; t++)
                    expQ.push_back(rec(1, 0, 2'b10, 0, r, 0, (k * D + t) % 2048, t * 8 + k % 8, expBuf));
                wr = (k * R + r) % 2048;
                expQ.push_back(rec(1, 0, 2'b11, p ? ((r % 2 == 1 || r == R - 1) ? 2'b10 : 2'b01) : 2'b00,
                                   0, p ? wr / 2 : wr, 0, 0, expBuf));
            end
        end
        expQ.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, expBuf));
        expBuf = ~expBuf;
        expQ.push_back(rec(1, 1, 0, 0, 0, 0, 0, 0, expBuf));
    endtask

    task automatic runLayer(int R, int K, bit p, int expBusy, bit noisy, bit hold);
        int busyCnt = 0;
        int n;
        buildTrace(R, K, p);
        n = expQ.size();
        @(negedge CLK);
        cfgRows = R[ABuffer-1:0];
        cfgKernels = K[depth:0];
        cfgPool = p;
        start = 1;
        @(negedge CLK);
        for (int i = 0; i < n; i++) begin
            chkRec("trace", actual(), expQ[i]);
            busyCnt += int'(busy);
            if (!hold) start = (noisy && i < n - 1) ? 1'($urandom) : 1'b0;
            if (noisy) begin
                cfgRows = ABuffer'($urandom);
                cfgKernels = (depth + 1)'($urandom);
                cfgPool = 1'($urandom);
            end
            @(negedge CLK);
        end
        chkInt("busy_cycles", busyCnt, expBusy);
        chkRec("idle_after", actual(), rec(0, 0, 0, 0, 0, 0, 0, 0, expBuf));
`ifdef SEQ_PERF_COUNTER_EN
        chkInt("cycle_count", cycleCount, expBusy);
`endif
    endtask

    task automatic resetPulse();
        @(negedge CLK);
        start = 0;
        RST_N = 0;
        @(negedge CLK);
        RST_N = 1;
        expBuf = 0;
    endtask

    vecT vecs[8];

    initial begin
        vecs[0] = '{2, 1, 0, 21};
        vecs[1] = '{4, 2, 1, 76};
        vecs[2] = '{0, 3, 0, 1};
        vecs[3] = '{3, 0, 1, 1};
        vecs[4] = '{1, 1, 0, 12};
        vecs[5] = '{3, 2, 1, 58};
        vecs[6] = '{5, 1, 1, 48};
        vecs[7] = '{1000, 3, 0, 27005};

        repeat (2) @(negedge CLK);
        chkRec("reset_state", actual(), rec(0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef SEQ_PERF_COUNTER_EN
        chkInt("reset_count", cycleCount, 0);
`endif
        RST_N = 1;

        foreach (vecs[i]) runLayer(vecs[i].rows, vecs[i].kernels, vecs[i].pool, vecs[i].expBusy, 0, 0);

        for (int i = 0; i < 10; i++) begin
            int R, K, eb;
            bit p;
            R = $urandom_range(0, 6);
            K = $urandom_range(0, 15);
            p = 1'($urandom);
            eb = (R == 0 || K == 0) ? 1 : K * (1 + R * (D + 1)) + 2;
            runLayer(R, K, p, eb, 1, 0);
        end

        // Asynchronous reset in the middle of kernel 1's MAC phase.
        resetPulse();
        @(negedge CLK);
        cfgRows = 2;
        cfgKernels = 2;
        cfgPool = 0;
        start = 1;
        @(negedge CLK);
        start = 0;
        repeat (21) @(negedge CLK);
        chkInt("pre_reset_kdc", kernelDistControl, 9);
        #2 RST_N = 0;
        #1 chkRec("async_reset", actual(), rec(0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef SEQ_PERF_COUNTER_EN
        chkInt("async_reset_count", cycleCount, 0);
`endif
        @(negedge CLK);
        RST_N = 1;
        expBuf = 0;
        runLayer(2, 2, 0, 40, 0, 0);

        // start held high: one full run, IDLE for a cycle, then a fresh run.
        runLayer(1, 1, 0, 12, 0, 1);
        @(negedge CLK);
        chkInt("restart_busy", busy, 1);
        chkInt("restart_clear", convUnitControl, 1);
        resetPulse();
        runLayer(2, 1, 0, 21, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter depth, default 3: log2 of lane count; D = 1<<depth.
REQ-002 SHALL have parameter ABuffer, default 11: neuron/kernel buffer address width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: layer start request.
REQ-006 SHALL have port cfgRows, input, ABuffer: neuron rows per kernel (R).
REQ-007 SHALL have port cfgKernels, input, depth+1: kernel count (K).
REQ-008 SHALL have port cfgPool, input, 1: 1 = 2:1 max-pool enabled.
REQ-009 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have ports nReadAddress and nWriteAddress, output, ABuffer each: neuron read/write addresses.
REQ-012 SHALL have port kBuffAddress, output, ABuffer: kernel buffer address.
REQ-013 SHALL have port kernelDistControl, output, 2*depth: distributor select {tap, kernel[depth-1:0]}.
REQ-014 SHALL have port convUnitControl, output, 2: 00 hold, 01 clear, 10 MAC, 11 write-out.
REQ-015 SHALL have port poolUnitControl, output, 2: 00 bypass, 01 accumulate, 10 emit, 11 unused.
REQ-016 SHALL have port bufSel, output, 1: neuron buffer swap select (0 = read N1/write N2).

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, MAC, WRITE, SWAP, DONE; all outputs decoded from registered state and counters only.
REQ-018 SHALL, in IDLE with start=1, latch cfgRows/cfgKernels/cfgPool, zero counters k, r, t, and enter CLEAR next cycle; start while busy SHALL be ignored.
REQ-019 SHALL, in IDLE with start=1 and latched R=0 or K=0, go directly to DONE without SWAP.
REQ-020 SHALL in CLEAR drive convUnitControl=01 for one cycle, then enter MAC.
REQ-021 SHALL in MAC drive convUnitControl=10, nReadAddress=r, kBuffAddress=k*D+t, kernelDistControl={t,k}; t increments each cycle; after t=D-1 enter WRITE.
REQ-022 SHALL in WRITE drive convUnitControl=11 for one cycle with nWriteAddress=k*R+r when cfgPool=0, else (k*R+r)>>1.
REQ-023 SHALL in WRITE drive poolUnitControl=00 if cfgPool=0; else 01 on even r and 10 on odd r (last even row with odd R SHALL emit 10).
REQ-024 SHALL after WRITE: r<R-1 -> r+1, MAC; r=R-1 and k<K-1 -> k+1, r=0, CLEAR; else SWAP.
REQ-025 SHALL in SWAP toggle bufSel for one cycle's transition, then DONE; DONE SHALL assert done=1 for exactly one cycle, then IDLE.
REQ-026 SHALL hold address outputs at 0 and control outputs at 00 in IDLE, SWAP, DONE.
REQ-027 SHALL truncate address arithmetic modulo 2^ABuffer (wrap, no saturation).
REQ-028 SHALL take K*(1+R*(D+1))+2 busy cycles for nonzero R, K; start-to-busy latency 1 cycle.

Reset
REQ-029 SHALL on RST_N=0 immediately force IDLE, bufSel=0, busy=0, done=0, all addresses and counters 0, controls 00, including mid-layer; no resume after release.

Configuration
REQ-030 SHALL, when SEQ_PERF_COUNTER_EN is defined, add output cycleCount (32 bits) counting busy cycles, cleared on accepted start, holding after DONE, reset to 0; without the macro the port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-031 D=8, R=2, K=1, cfgPool=0, start pulse -> 21 busy cycles, writes at 0 and 1, done one pulse, bufSel 0->1.
REQ-032 R=4, K=2, cfgPool=1 -> poolUnitControl 01,10,01,10 per kernel; write addresses 0,0,1,1,2,2,3,3.
REQ-033 R=0, K=3 start -> busy 1 cycle (DONE), done pulse, bufSel unchanged.
REQ-034 RST_N low in MAC of kernel 1 -> all outputs 0 same cycle; new start runs full layer from k=0.
REQ-035 start held high across whole layer -> exactly one layer run, then a second run starts from IDLE on the cycle after DONE.
REQ-036 With SEQ_PERF_COUNTER_EN, REQ-031 stimulus -> cycleCount=21 after done.
